// File: rtl/mem_stage_v.sv
// Memory-access stage: a two-state controller drives a req/ack data bus for
// byte/half/word loads and stores, steers store lanes, extends load data, and
// registers the retired instruction into the MEM/WB outputs.
module mem_stage_v #(
   parameter int ADDR_BITS = 32,
   parameter int RD_BITS   = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ex_valid,
   input  logic                 ex_is_memRead,
   input  logic                 ex_is_memWrite,
   input  logic [2:0]           ex_funct3,
   input  logic [31:0]          ex_alu_data,
   input  logic [31:0]          ex_store_data,
   input  logic [RD_BITS-1:0]   ex_rd,
   input  logic                 ex_regWrite,
   output logic                 stall_o,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [ADDR_BITS-1:0] dmem_addr,
   output logic [31:0]          dmem_wdata,
   output logic [3:0]           dmem_wstrb,
   input  logic [31:0]          dmem_rdata,
   input  logic                 dmem_ack,
   output logic                 wb_valid,
   output logic                 is_memRead,
   output logic                 is_memWrite,
   output logic [31:0]          mem_data,
   output logic [31:0]          alu_data,
   output logic [RD_BITS-1:0]   rd,
   output logic                 regWrite,
   output logic                 mem_fault
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_q, state_d;
   // Captured memory operation, held for the whole transaction.
   logic [2:0]           op_funct3_q, op_funct3_d;
   logic [1:0]           op_lo_q, op_lo_d;
   logic                 op_rd_q, op_rd_d;
   logic                 op_wr_q, op_wr_d;
   logic [31:0]          op_alu_q, op_alu_d;
   logic [31:0]          op_store_q, op_store_d;
   logic [RD_BITS-1:0]   op_rdidx_q, op_rdidx_d;
   logic                 op_rw_q, op_rw_d;
   // Bus and MEM/WB output registers.
   logic                 dmem_req_q, dmem_req_d;
   logic                 dmem_we_q, dmem_we_d;
   logic [ADDR_BITS-1:0] dmem_addr_q, dmem_addr_d;
   logic [31:0]          dmem_wdata_q, dmem_wdata_d;
   logic [3:0]           dmem_wstrb_q, dmem_wstrb_d;
   logic                 wb_valid_q, wb_valid_d;
   logic                 is_memRead_q, is_memRead_d;
   logic                 is_memWrite_q, is_memWrite_d;
   logic [31:0]          mem_data_q, mem_data_d;
   logic [31:0]          alu_data_q, alu_data_d;
   logic [RD_BITS-1:0]   rd_q, rd_d;
   logic                 regWrite_q, regWrite_d;
   logic                 mem_fault_q, mem_fault_d;

   logic                 ex_mem_op;
   logic                 ex_legal;
   logic [31:0]          st_wdata;
   logic [3:0]           st_wstrb;
   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;
   logic [31:0]          ld_ext;

   assign ex_mem_op = ex_is_memRead | ex_is_memWrite;

   // Decide whether the incoming memory op is a legal, aligned access.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
      ex_legal = 1'b0;
      if (!(ex_is_memRead && ex_is_memWrite)) begin
         case (ex_funct3)
            F3_B:    ex_legal = 1'b1;
            F3_H:    ex_legal = ~ex_alu_data[0];
            F3_W:    ex_legal = (ex_alu_data[1:0] == 2'b00);
            F3_BU:   ex_legal = ex_is_memRead;
            F3_HU:   ex_legal = ex_is_memRead & ~ex_alu_data[0];
            default: ex_legal = 1'b0;
         endcase
      end
   end

   // Replicate store data across lanes and pick the byte strobes.
   always_comb begin
      st_wdata = ex_store_data;
      st_wstrb = 4'b1111;
      case (ex_funct3[1:0])
         2'b00: begin
            st_wdata = {4{ex_store_data[7:0]}};
            st_wstrb = 4'b0001 << ex_alu_data[1:0];
         end
         2'b01: begin
            st_wdata = {2{ex_store_data[15:0]}};
            st_wstrb = ex_alu_data[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Select the addressed byte/half of the read word and extend it.
   always_comb begin
      case (op_lo_q)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = op_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (op_funct3_q)
         F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_ext = {24'd0, ld_byte};
         F3_HU:   ld_ext = {16'd0, ld_half};
         default: ld_ext = dmem_rdata;
      endcase
   end

   // Next-state and next-output logic of the IDLE/BUSY controller.
   always_comb begin
      state_d       = state_q;
      op_funct3_d   = op_funct3_q;
      op_lo_d       = op_lo_q;
      op_rd_d       = op_rd_q;
      op_wr_d       = op_wr_q;
      op_alu_d      = op_alu_q;
      op_store_d    = op_store_q;
      op_rdidx_d    = op_rdidx_q;
      op_rw_d       = op_rw_q;
      dmem_req_d    = dmem_req_q;
      dmem_we_d     = dmem_we_q;
      dmem_addr_d   = dmem_addr_q;
      dmem_wdata_d  = dmem_wdata_q;
      dmem_wstrb_d  = dmem_wstrb_q;
      is_memRead_d  = is_memRead_q;
      is_memWrite_d = is_memWrite_q;
      mem_data_d    = mem_data_q;
      alu_data_d    = alu_data_q;
      rd_d          = rd_q;
      wb_valid_d    = 1'b0;
      regWrite_d    = 1'b0;
      mem_fault_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (ex_valid && !ex_mem_op) begin
               wb_valid_d    = 1'b1;
               is_memRead_d  = 1'b0;
               is_memWrite_d = 1'b0;
               mem_data_d    = 32'd0;
               alu_data_d    = ex_alu_data;
               rd_d          = ex_rd;
               regWrite_d    = ex_regWrite;
            end else if (ex_valid && !ex_legal) begin
               wb_valid_d    = 1'b1;
               mem_fault_d   = 1'b1;
               is_memRead_d  = ex_is_memRead;
               is_memWrite_d = ex_is_memWrite;
               mem_data_d    = 32'd0;
               alu_data_d    = ex_alu_data;
               rd_d          = ex_rd;
            end else if (ex_valid) begin
               state_d      = BUSY;
               op_funct3_d  = ex_funct3;
               op_lo_d      = ex_alu_data[1:0];
               op_rd_d      = ex_is_memRead;
               op_wr_d      = ex_is_memWrite;
               op_alu_d     = ex_alu_data;
               op_store_d   = ex_store_data;
               op_rdidx_d   = ex_rd;
               op_rw_d      = ex_regWrite;
               dmem_req_d   = 1'b1;
               dmem_we_d    = ex_is_memWrite;
               dmem_addr_d  = {ex_alu_data[ADDR_BITS-1:2], 2'b00};
               dmem_wdata_d = ex_is_memWrite ? st_wdata : 32'd0;
               dmem_wstrb_d = ex_is_memWrite ? st_wstrb : 4'b0000;
            end
         end
         BUSY: begin
            if (dmem_ack) begin
               state_d       = IDLE;
               dmem_req_d    = 1'b0;
               dmem_we_d     = 1'b0;
               wb_valid_d    = 1'b1;
               is_memRead_d  = op_rd_q;
               is_memWrite_d = op_wr_q;
               mem_data_d    = op_rd_q ? ld_ext : op_store_q;
               alu_data_d    = op_alu_q;
               rd_d          = op_rdidx_q;
               regWrite_d    = op_rd_q & op_rw_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, capture, bus and MEM/WB registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         op_funct3_q   <= 3'd0;
         op_lo_q       <= 2'd0;
         op_rd_q       <= 1'b0;
         op_wr_q       <= 1'b0;
         op_alu_q      <= 32'd0;
         op_store_q    <= 32'd0;
         op_rdidx_q    <= '0;
         op_rw_q       <= 1'b0;
         dmem_req_q    <= 1'b0;
         dmem_we_q     <= 1'b0;
         dmem_addr_q   <= '0;
         dmem_wdata_q  <= 32'd0;
         dmem_wstrb_q  <= 4'd0;
         wb_valid_q    <= 1'b0;
         is_memRead_q  <= 1'b0;
         is_memWrite_q <= 1'b0;
         mem_data_q    <= 32'd0;
         alu_data_q    <= 32'd0;
         rd_q          <= '0;
         regWrite_q    <= 1'b0;
         mem_fault_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values of its neighbours.
         state_q       <= state_d;
         op_funct3_q   <= op_funct3_d;
         op_lo_q       <= op_lo_d;
         op_rd_q       <= op_rd_d;
         op_wr_q       <= op_wr_d;
         op_alu_q      <= op_alu_d;
         op_store_q    <= op_store_d;
         op_rdidx_q    <= op_rdidx_d;
         op_rw_q       <= op_rw_d;
         dmem_req_q    <= dmem_req_d;
         dmem_we_q     <= dmem_we_d;
         dmem_addr_q   <= dmem_addr_d;
         dmem_wdata_q  <= dmem_wdata_d;
         dmem_wstrb_q  <= dmem_wstrb_d;
         wb_valid_q    <= wb_valid_d;
         is_memRead_q  <= is_memRead_d;
         is_memWrite_q <= is_memWrite_d;
         mem_data_q    <= mem_data_d;
         alu_data_q    <= alu_data_d;
         rd_q          <= rd_d;
         regWrite_q    <= regWrite_d;
         mem_fault_q   <= mem_fault_d;
      end
   end

   assign stall_o     = (state_q == BUSY);
   assign dmem_req    = dmem_req_q;
   assign dmem_we     = dmem_we_q;
   assign dmem_addr   = dmem_addr_q;
   assign dmem_wdata  = dmem_wdata_q;
   assign dmem_wstrb  = dmem_wstrb_q;
   assign wb_valid    = wb_valid_q;
   assign is_memRead  = is_memRead_q;
   assign is_memWrite = is_memWrite_q;
   assign mem_data    = mem_data_q;
   assign alu_data    = alu_data_q;
   assign rd          = rd_q;
   assign regWrite    = regWrite_q;
   assign mem_fault   = mem_fault_q;

endmodule

// File: tb/tb_mem_stage_v.sv
// Directed bench for mem_stage_v: expected MEM/WB results are queued when an
// instruction is driven and popped when wb_valid pulses.
module tb_mem_stage_v;

   logic        clk;
   logic        reset;
   logic        ex_valid;
   logic        ex_is_memRead;
   logic        ex_is_memWrite;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu_data;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_regWrite;
   logic        stall_o;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic        is_memRead;
   logic        is_memWrite;
   logic [31:0] mem_data;
   logic [31:0] alu_data;
   logic [4:0]  rd;
   logic        regWrite;
   logic        mem_fault;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] alu;
      logic [4:0]  rdi;
      logic        rw;
      logic [31:0] md;
      logic        cmp_md;
      logic        fault;
      logic        is_rd;
      logic        is_wr;
   } wb_exp_t;

   wb_exp_t sb_q[$];

   mem_stage_v #(.ADDR_BITS(32), .RD_BITS(5)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_is_memRead(ex_is_memRead), .ex_is_memWrite(ex_is_memWrite),
      .ex_funct3(ex_funct3), .ex_alu_data(ex_alu_data), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .stall_o(stall_o),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .wb_valid(wb_valid), .is_memRead(is_memRead),
      .is_memWrite(is_memWrite), .mem_data(mem_data), .alu_data(alu_data),
      .rd(rd), .regWrite(regWrite), .mem_fault(mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] f3, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rdi, input logic rw);
      ex_valid       = 1'b1;
      ex_is_memRead  = r;
      ex_is_memWrite = w;
      ex_funct3      = f3;
      ex_alu_data    = a;
      ex_store_data  = sd;
      ex_rd          = rdi;
      ex_regWrite    = rw;
   endtask

   // Expect a retirement this cycle and compare it against the oldest entry.
   task automatic check_wb(input string tag);
      wb_exp_t e;
      check({tag, "_wb_valid"}, wb_valid, 1);
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_sb: observed=retirement expected=empty scoreboard", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_alu"}, alu_data, e.alu);
         check({tag, "_rd"}, rd, e.rdi);
         check({tag, "_regWrite"}, regWrite, e.rw);
         check({tag, "_fault"}, mem_fault, e.fault);
         check({tag, "_is_rd"}, is_memRead, e.is_rd);
         check({tag, "_is_wr"}, is_memWrite, e.is_wr);
         if (e.cmp_md) check({tag, "_mem_data"}, mem_data, e.md);
      end
   endtask

   // Legal memory op: accept, hold the bus for `waits` cycles, ack, retire.
   task automatic mem_op(input string tag, input logic [2:0] f3, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rdi,
                         input logic rw, input logic [31:0] rdata, input int waits,
                         input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                         input logic [31:0] e_md);
      drive(f3, r, w, a, sd, rdi, rw);
      sb_q.push_back('{a, rdi, r & rw, e_md, 1'b1, 1'b0, r, w});
      check({tag, "_stall_idle"}, stall_o, 0);
      step();
      // A non-memory op presented while BUSY must be ignored.
      drive(3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd31, 1'b1);
      check({tag, "_req"}, dmem_req, 1);
      check({tag, "_we"}, dmem_we, w);
      check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
      check({tag, "_wstrb"}, dmem_wstrb, e_wstrb);
      if (w) check({tag, "_wdata"}, dmem_wdata, e_wdata);
      check({tag, "_stall"}, stall_o, 1);
      check({tag, "_no_wb"}, wb_valid, 0);
      for (int i = 0; i < waits; i++) begin
         step();
         check({tag, "_req_hold"}, dmem_req, 1);
         check({tag, "_addr_hold"}, dmem_addr, {a[31:2], 2'b00});
         check({tag, "_wstrb_hold"}, dmem_wstrb, e_wstrb);
         check({tag, "_stall_hold"}, stall_o, 1);
         check({tag, "_no_wb_wait"}, wb_valid, 0);
      end
      dmem_rdata = rdata;
      dmem_ack   = 1'b1;
      #1;
      check({tag, "_stall_ack"}, stall_o, 1);
      step();
      ex_valid   = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      check({tag, "_req_drop"}, dmem_req, 0);
      check({tag, "_stall_done"}, stall_o, 0);
      check_wb(tag);
   endtask

   // Illegal memory op: no bus access, faulting retirement on the next edge.
   task automatic fault_op(input string tag, input logic [2:0] f3, input logic r, input logic w,
                           input logic [31:0] a, input logic [4:0] rdi);
      drive(f3, r, w, a, 32'h1234_5678, rdi, 1'b1);
      sb_q.push_back('{a, rdi, 1'b0, 32'h0, 1'b0, 1'b1, r, w});
      step();
      ex_valid = 1'b0;
      check({tag, "_no_req"}, dmem_req, 0);
      check({tag, "_stall"}, stall_o, 0);
      check_wb(tag);
      step();
      check({tag, "_pulse_end"}, wb_valid, 0);
      check({tag, "_fault_end"}, mem_fault, 0);
   endtask

   initial begin
      reset          = 1'b1;
      ex_valid       = 1'b0;
      ex_is_memRead  = 1'b0;
      ex_is_memWrite = 1'b0;
      ex_funct3      = 3'b000;
      ex_alu_data    = 32'h0;
      ex_store_data  = 32'h0;
      ex_rd          = 5'd0;
      ex_regWrite    = 1'b0;
      dmem_rdata     = 32'h0;
      dmem_ack       = 1'b0;
      #12;
      check("rst_wb_valid", wb_valid, 0);
      check("rst_req", dmem_req, 0);
      check("rst_stall", stall_o, 0);
      check("rst_regWrite", regWrite, 0);
      check("rst_alu", alu_data, 0);
      check("rst_mem_data", mem_data, 0);
      reset = 1'b0;

      // ADD: single-cycle pass-through.
      drive(3'b000, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd5, 1'b1);
      sb_q.push_back('{32'h10, 5'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      check("add_stall", stall_o, 0);
      step();
      ex_valid = 1'b0;
      check("add_stall_after", stall_o, 0);
      check_wb("add");
      step();
      check("bubble_wb", wb_valid, 0);
      check("bubble_regWrite", regWrite, 0);
      check("bubble_hold_alu", alu_data, 32'h10);

      // Loads with lane selection and extension.
      mem_op("lb",  3'b000, 1, 0, 32'h103, 32'h0, 5'd7, 1, 32'h80FF_1234, 3, 32'h0, 4'b0000, 32'hFFFF_FF80);
      mem_op("lbu", 3'b100, 1, 0, 32'h103, 32'h0, 5'd8, 1, 32'h80FF_1234, 3, 32'h0, 4'b0000, 32'h0000_0080);
      mem_op("lh",  3'b001, 1, 0, 32'h102, 32'h0, 5'd9, 1, 32'h80FF_1234, 1, 32'h0, 4'b0000, 32'hFFFF_80FF);
      mem_op("lhu", 3'b101, 1, 0, 32'h102, 32'h0, 5'd10, 1, 32'h80FF_1234, 1, 32'h0, 4'b0000, 32'h0000_80FF);

      // Stores with lane steering.
      mem_op("sh", 3'b001, 0, 1, 32'h22, 32'h0000_BEEF, 5'd11, 1, 32'h0, 1, 32'hBEEF_BEEF, 4'b1100, 32'h0000_BEEF);
      mem_op("sb", 3'b000, 0, 1, 32'h101, 32'h1234_56A5, 5'd12, 1, 32'h0, 0, 32'hA5A5_A5A5, 4'b0010, 32'h1234_56A5);

      // Illegal accesses.
      fault_op("lw_misal", 3'b010, 1, 0, 32'h06, 5'd13);
      fault_op("st_f3_100", 3'b100, 0, 1, 32'h40, 5'd14);
      fault_op("lh_misal", 3'b001, 1, 0, 32'h101, 5'd15);
      fault_op("rd_and_wr", 3'b010, 1, 1, 32'h08, 5'd16);
      fault_op("ld_f3_011", 3'b011, 1, 0, 32'h10, 5'd17);

      // Back-to-back zero-wait LW then SW.
      mem_op("b2b_lw", 3'b010, 1, 0, 32'h40, 32'h0, 5'd18, 1, 32'hCAFE_F00D, 0, 32'h0, 4'b0000, 32'hCAFE_F00D);
      mem_op("b2b_sw", 3'b010, 0, 1, 32'h44, 32'h1122_3344, 5'd19, 0, 32'h0, 0, 32'h1122_3344, 4'b1111, 32'h1122_3344);

      // Spurious ack while IDLE.
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      check("spur_req", dmem_req, 0);
      check("spur_wb", wb_valid, 0);
      check("spur_stall", stall_o, 0);

      // Reset in the middle of a BUSY transaction.
      drive(3'b010, 1'b1, 1'b0, 32'h80, 32'h0, 5'd20, 1'b1);
      step();
      ex_valid = 1'b0;
      check("mid_req", dmem_req, 1);
      step();
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_req", dmem_req, 0);
      check("mid_rst_stall", stall_o, 0);
      check("mid_rst_wb", wb_valid, 0);
      check("mid_rst_alu", alu_data, 0);
      check("mid_rst_rd", rd, 0);
      check("mid_rst_mem_data", mem_data, 0);
      #2;
      reset = 1'b0;
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      check("post_rst_wb", wb_valid, 0);
      check("post_rst_req", dmem_req, 0);
      check("sb_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_v.md
Name: mem_stage_v

Overview:
- Memory-access stage of the 5-stage CPU. Sits between EX/MEM and the writeback mux.
- Takes the ALU result and store data from EX. Performs byte/half/word loads and stores over a req/ack data-memory bus, including lane steering and load sign/zero extension.
- Registers the result into the MEM/WB outputs consumed by writeback. Stalls upstream while a bus transaction is outstanding.

Parameters:
- ADDR_BITS, 32, width of dmem_addr (taken from alu_data LSBs).
- RD_BITS, 5, destination register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_is_memRead  in  1  load.
- ex_is_memWrite  in  1  store.
- ex_funct3  in  3  access size/sign.
- ex_alu_data  in  32  ALU result / effective address.
- ex_store_data  in  32  rs2 value for stores.
- ex_rd  in  RD_BITS  destination register.
- ex_regWrite  in  1  instruction writes rd.
- stall_o  out  1  upstream must hold EX/MEM.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  ADDR_BITS  word-aligned address (bits[1:0]=0).
- dmem_wdata  out  32  lane-steered store data.
- dmem_wstrb  out  4  byte strobes.
- dmem_rdata  in  32  read word.
- dmem_ack  in  1  transaction complete.
- wb_valid  out  1  MEM/WB output valid.
- is_memRead  out  1  to WB.
- is_memWrite  out  1  to WB.
- mem_data  out  32  extended load data, or raw store data for stores.
- alu_data  out  32  passed-through ALU result.
- rd  out  RD_BITS  to WB.
- regWrite  out  1  gated: 0 unless wb_valid and no fault.
- mem_fault  out  1  misaligned or illegal access, pulses with wb_valid.

Behaviour:
- Reset: async, active-high. All outputs clear to 0, state IDLE. Reset mid-transaction drops dmem_req immediately and discards the instruction; no wb_valid.
- FSM states: IDLE, BUSY.
- IDLE, ex_valid=0: next edge wb_valid=0 (bubble), regWrite=0.
- IDLE, ex_valid=1, non-memory op: next edge wb_valid=1, alu_data/rd/regWrite registered, mem_data=0. Latency 1. Stay IDLE.
- IDLE, ex_valid=1, memory op, legal and aligned: capture op, state BUSY, dmem_req=1 with addr/we/wdata/wstrb registered. wb_valid=0.
- Legality: LB/SB 000 (any offset), LH/SH 001 (addr[0]=0), LW/SW 010 (addr[1:0]=0), LBU 100, LHU 101 (loads only).
- Illegal cases: misaligned access, any other funct3, store with 1xx, or memRead and memWrite both set.
  - No bus access.
  - Next edge: wb_valid=1, mem_fault=1, regWrite=0.
- BUSY:
  - stall_o=1 for the whole of BUSY, including the ack cycle.
  - dmem_req and all bus fields held stable until dmem_ack samples 1.
  - On the ack edge: dmem_req=0, state IDLE, wb_valid=1 for one cycle.
    - Load: mem_data = selected byte/half of dmem_rdata by addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU); word unchanged for LW. regWrite = captured regWrite.
    - Store: mem_data = ex_store_data unmodified, regWrite=0.
- Minimum memory-op latency: ack in the first BUSY cycle gives wb_valid 2 edges after acceptance.
- The next instruction is accepted on the first edge after returning to IDLE.
- dmem_ack in IDLE is ignored.
- stall_o=0 in IDLE. ex_* inputs are ignored while BUSY.
- Store steering:
  - SB: byte replicated on all lanes, wstrb = 1<<addr[1:0].
  - SH: half replicated, wstrb 0011 or 1100.
  - SW: wstrb 1111.
- Loads: dmem_we=0, wstrb=0000.
- wb_valid is a one-cycle pulse per retired instruction. Outputs other than wb_valid hold their last value during bubbles, but regWrite is forced 0.

Test Plan:
- Reset held during a BUSY transaction -> dmem_req=0, wb_valid=0, state IDLE, all outputs 0 immediately (asynchronous, no clock edge needed).
- ADD, alu 0x0000_0010, rd=5, regWrite=1 -> one edge later: wb_valid=1, alu_data=0x10, rd=5, regWrite=1, stall_o never high.
- LB addr 0x103, rdata 0x80FF_1234, ack after 3 BUSY cycles:
  - dmem_addr=0x100 and req held stable for 3 cycles, stall_o high throughout.
  - After the ack edge: mem_data=0xFFFF_FF80, regWrite=1.
  - Repeat with LBU -> mem_data=0x0000_0080.
- SH addr 0x22, store 0x0000_BEEF -> dmem_we=1, wstrb=1100, wdata=0xBEEF_BEEF, addr=0x20; after ack: regWrite=0, mem_data=0x0000_BEEF.
- LW addr 0x06 -> no dmem_req; next edge: wb_valid=1, mem_fault=1, regWrite=0.
  - Store with funct3=100 gives the same response.
- Back-to-back LW 0x40 then SW 0x44, zero-wait ack:
  - Two transactions in order, second req starts the edge after the first returns to IDLE.
  - Spurious dmem_ack while IDLE has no effect.
